// File: rtl/sys_defs.sv
// Shared machine widths and the common-data-bus payload type.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif
`ifndef PRF_WIDTH
`define PRF_WIDTH 6
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif
`define CDB_PACKET_WIDTH (`PRF_WIDTH + `ROB_WIDTH + 1)

package sys_defs;

   localparam int unsigned CDB_PACKET_W = `CDB_PACKET_WIDTH;

   typedef struct packed {
      logic [`PRF_WIDTH-1:0] dest_prn;
      logic [`ROB_WIDTH:0]   rob_entry;
   } CDB_PACKET;

endpackage

`endif

// File: rtl/cdb_fifo.sv
// Per-FU completion FIFO: wrap-bit pointers, flush, simultaneous push and pop.
module cdb_fifo #(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout_c,
   output logic                  full_c,
   output logic                  empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   assign empty_c = (wr_ptr_q == rd_ptr_q);
   assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout_c  = mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full FIFO is ignored even when a pop frees a slot that edge.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push && !full_c) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         end
         if (pop && !empty_c) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU completion FIFOs, multi-slot grant, registered bus.
// CDB_RR_ARB_EN selects rotating priority; otherwise FU 0 has fixed highest priority.
module cdb_arbiter
   import sys_defs::*;
#(
   parameter int unsigned FU_NUM      = 4,
   parameter int unsigned FIFO_DEPTH  = 2,
   parameter int unsigned ISSUE_WIDTH = `ISSUE_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pipe_flush,
   input  logic [FU_NUM-1:0]      fu_done_valid,
   output logic [FU_NUM-1:0]      fu_done_ready,
   input  CDB_PACKET              fu_done_pkt [0:FU_NUM-1],
   output logic [ISSUE_WIDTH-1:0] cdb_valid,
   output logic [`PRF_WIDTH-1:0]  cdb_prn [0:ISSUE_WIDTH-1],
   output logic [`ROB_WIDTH:0]    cdb_rob_entry [0:ISSUE_WIDTH-1],
   output logic [FU_NUM-1:0]      cdb_stall
);

   localparam int unsigned IDX_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

   logic [FU_NUM-1:0]      full_c, empty_c, push_c, pop_c, req_c, grant_c;
   CDB_PACKET              head_c [FU_NUM];
   logic [ISSUE_WIDTH-1:0] slot_vld_c;
   logic [IDX_W-1:0]       slot_fu_c [ISSUE_WIDTH];
   logic [IDX_W-1:0]       base_c;

   logic [ISSUE_WIDTH-1:0] cdb_valid_q, cdb_valid_d;
   logic [`PRF_WIDTH-1:0]  cdb_prn_q [ISSUE_WIDTH];
   logic [`PRF_WIDTH-1:0]  cdb_prn_d [ISSUE_WIDTH];
   logic [`ROB_WIDTH:0]    cdb_rob_q [ISSUE_WIDTH];
   logic [`ROB_WIDTH:0]    cdb_rob_d [ISSUE_WIDTH];

   assign req_c         = ~empty_c;
   assign fu_done_ready = ~full_c;
   assign push_c        = fu_done_valid & ~full_c & {FU_NUM{~pipe_flush}};
   assign pop_c         = grant_c & {FU_NUM{~pipe_flush}};
   assign cdb_stall     = req_c & ~grant_c;

   for (genvar g = 0; g < int'(FU_NUM); g++) begin : g_fifo
      cdb_fifo #(
         .DEPTH      (FIFO_DEPTH),
         .DATA_WIDTH (CDB_PACKET_W)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .flush   (pipe_flush),
         .push    (push_c[g]),
         .pop     (pop_c[g]),
         .din     (fu_done_pkt[g]),
         .dout_c  (head_c[g]),
         .full_c  (full_c[g]),
         .empty_c (empty_c[g])
      );
   end

`ifdef CDB_RR_ARB_EN
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] last_fu_c;

   assign base_c = rr_ptr_q;

   // Next search starts just past the lowest-priority FU granted this cycle.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (!pipe_flush && (|grant_c)) begin
         rr_ptr_d = IDX_W'((32'(last_fu_c) + 32'd1) % FU_NUM);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end
`else
   assign base_c = '0;
`endif

   // One pass per slot, each picking the first still-ungranted requester in priority order.
   always_comb begin
      logic [FU_NUM-1:0] rem;
      logic [31:0]       fu;
      grant_c    = '0;
      slot_vld_c = '0;
      rem        = req_c;
      fu         = '0;
`ifdef CDB_RR_ARB_EN
      last_fu_c  = '0;
`endif
      for (int k = 0; k < int'(ISSUE_WIDTH); k++) slot_fu_c[k] = '0;
      for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
         for (int p = 0; p < int'(FU_NUM); p++) begin
            fu = (32'(base_c) + 32'(p)) % FU_NUM;
            if (!slot_vld_c[k] && rem[IDX_W'(fu)]) begin
               slot_vld_c[k]         = 1'b1;
               slot_fu_c[k]          = IDX_W'(fu);
               rem[IDX_W'(fu)]       = 1'b0;
               grant_c[IDX_W'(fu)]   = 1'b1;
`ifdef CDB_RR_ARB_EN
               last_fu_c             = IDX_W'(fu);
`endif
            end
         end
      end
   end

   // Bus register is reloaded every cycle; idle slots carry zero tags.
   always_comb begin
      cdb_valid_d = slot_vld_c;
      for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
         cdb_prn_d[k] = '0;
         cdb_rob_d[k] = '0;
         if (slot_vld_c[k] && !pipe_flush) begin
            cdb_prn_d[k] = head_c[slot_fu_c[k]].dest_prn;
            cdb_rob_d[k] = head_c[slot_fu_c[k]].rob_entry;
         end
      end
      if (pipe_flush) cdb_valid_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid_q <= '0;
         for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
            cdb_prn_q[k] <= '0;
            cdb_rob_q[k] <= '0;
         end
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_prn_q   <= cdb_prn_d;
         cdb_rob_q   <= cdb_rob_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   for (genvar k = 0; k < int'(ISSUE_WIDTH); k++) begin : g_out
      assign cdb_prn[k]       = cdb_prn_q[k];
      assign cdb_rob_entry[k] = cdb_rob_q[k];
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (FU_NUM=4, FIFO_DEPTH=2, ISSUE_WIDTH=2).
module tb_cdb_arbiter;
   import sys_defs::*;

   localparam int unsigned FU_NUM = 4;
   localparam int unsigned IW     = `ISSUE_WIDTH;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  pipe_flush;
   logic [FU_NUM-1:0]     fu_done_valid;
   logic [FU_NUM-1:0]     fu_done_ready;
   CDB_PACKET             fu_done_pkt [0:FU_NUM-1];
   logic [IW-1:0]         cdb_valid;
   logic [`PRF_WIDTH-1:0] cdb_prn [0:IW-1];
   logic [`ROB_WIDTH:0]   cdb_rob_entry [0:IW-1];
   logic [FU_NUM-1:0]     cdb_stall;

   int errors = 0;
   int checks = 0;

   cdb_arbiter #(.FU_NUM(FU_NUM), .FIFO_DEPTH(2), .ISSUE_WIDTH(IW)) dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_flush    (pipe_flush),
      .fu_done_valid (fu_done_valid),
      .fu_done_ready (fu_done_ready),
      .fu_done_pkt   (fu_done_pkt),
      .cdb_valid     (cdb_valid),
      .cdb_prn       (cdb_prn),
      .cdb_rob_entry (cdb_rob_entry),
      .cdb_stall     (cdb_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pkt(input int i, input int prn, input int rob);
      fu_done_pkt[i].dest_prn  = `PRF_WIDTH'(prn);
      fu_done_pkt[i].rob_entry = (`ROB_WIDTH+1)'(rob);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      pipe_flush    = 1'b0;
      fu_done_valid = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      pipe_flush    = 1'b0;
      fu_done_valid = '0;
      for (int i = 0; i < int'(FU_NUM); i++) set_pkt(i, 0, 0);

      // Reset state
      do_reset();
      chk("rst_valid", 32'(cdb_valid), 32'h0);
      chk("rst_prn0", 32'(cdb_prn[0]), 32'h0);
      chk("rst_rob0", 32'(cdb_rob_entry[0]), 32'h0);
      chk("rst_ready", 32'(fu_done_ready), 32'hF);
      chk("rst_stall", 32'(cdb_stall), 32'h0);

      // 1: single FU2 completion, one-cycle latency after acceptance
      set_pkt(2, 7, 5);
      fu_done_valid = 4'b0100;
      step();
      fu_done_valid = '0;
      chk("t1_valid_e0", 32'(cdb_valid), 32'h0);
      chk("t1_stall_e0", 32'(cdb_stall), 32'h0);
      step();
      chk("t1_valid_e1", 32'(cdb_valid), 32'h1);
      chk("t1_prn0", 32'(cdb_prn[0]), 32'd7);
      chk("t1_rob0", 32'(cdb_rob_entry[0]), 32'd5);
      step();
      chk("t1_valid_e2", 32'(cdb_valid), 32'h0);

      // 2: all four FUs complete at once
      do_reset();
      for (int i = 0; i < int'(FU_NUM); i++) set_pkt(i, 10 + i, 20 + i);
      fu_done_valid = 4'hF;
      step();
      fu_done_valid = '0;
      chk("t2_stall_e0", 32'(cdb_stall), 32'hC);
      step();
      chk("t2_valid_e1", 32'(cdb_valid), 32'h3);
      chk("t2_prn0_e1", 32'(cdb_prn[0]), 32'd10);
      chk("t2_prn1_e1", 32'(cdb_prn[1]), 32'd11);
      chk("t2_rob1_e1", 32'(cdb_rob_entry[1]), 32'd21);
      chk("t2_stall_e1", 32'(cdb_stall), 32'h0);
      step();
      chk("t2_valid_e2", 32'(cdb_valid), 32'h3);
      chk("t2_prn0_e2", 32'(cdb_prn[0]), 32'd12);
      chk("t2_prn1_e2", 32'(cdb_prn[1]), 32'd13);
      step();
      chk("t2_valid_e3", 32'(cdb_valid), 32'h0);

      // 3: three FUs push every cycle into two slots
      do_reset();
      set_pkt(0, 1, 1);
      set_pkt(1, 2, 2);
      set_pkt(2, 3, 3);
      fu_done_valid = 4'b0111;
      step();
      chk("t3_stall_e0", 32'(cdb_stall), 32'h4);
      step();
      chk("t3_valid_e1", 32'(cdb_valid), 32'h3);
      chk("t3_prn0_e1", 32'(cdb_prn[0]), 32'd1);
      chk("t3_prn1_e1", 32'(cdb_prn[1]), 32'd2);
      chk("t3_ready_e1", 32'(fu_done_ready), 32'hB);
`ifdef CDB_RR_ARB_EN
      chk("t3_stall_e1", 32'(cdb_stall), 32'h2);
      step();
      chk("t3_prn0_e2", 32'(cdb_prn[0]), 32'd3);
      chk("t3_prn1_e2", 32'(cdb_prn[1]), 32'd1);
      chk("t3_ready_e2", 32'(fu_done_ready), 32'hD);
      chk("t3_stall_e2", 32'(cdb_stall), 32'h1);
`else
      chk("t3_stall_e1", 32'(cdb_stall), 32'h4);
      step();
      chk("t3_prn0_e2", 32'(cdb_prn[0]), 32'd1);
      chk("t3_prn1_e2", 32'(cdb_prn[1]), 32'd2);
      chk("t3_ready_e2", 32'(fu_done_ready), 32'hB);
      chk("t3_stall_e2", 32'(cdb_stall), 32'h4);
`endif
      fu_done_valid = '0;

      // 4: full FIFO popped while a push is offered; the push is refused
      do_reset();
      set_pkt(0, 1, 1);
      set_pkt(1, 2, 2);
      set_pkt(3, 30, 30);
      fu_done_valid = 4'b1011;
      step();
      fu_done_valid = 4'b1000;
      set_pkt(3, 31, 31);
      step();
      chk("t4_valid_e1", 32'(cdb_valid), 32'h3);
      chk("t4_ready_full", 32'(fu_done_ready), 32'h7);
      chk("t4_stall_e1", 32'(cdb_stall), 32'h0);
      set_pkt(3, 32, 32);
      step();
      chk("t4_valid_e2", 32'(cdb_valid), 32'h1);
      chk("t4_prn0_e2", 32'(cdb_prn[0]), 32'd30);
      chk("t4_ready_e2", 32'(fu_done_ready), 32'hF);
      fu_done_valid = '0;
      step();
      chk("t4_valid_e3", 32'(cdb_valid), 32'h1);
      chk("t4_prn0_e3", 32'(cdb_prn[0]), 32'd31);
      chk("t4_rob0_e3", 32'(cdb_rob_entry[0]), 32'd31);
      step();
      chk("t4_valid_e4", 32'(cdb_valid), 32'h0);

      // 5: flush with three FIFOs occupied; same-cycle push is dropped
      do_reset();
      for (int i = 0; i < 3; i++) set_pkt(i, 40 + i, 40 + i);
      set_pkt(3, 43, 43);
      fu_done_valid = 4'b0111;
      step();
      chk("t5_stall_e0", 32'(cdb_stall), 32'h4);
      fu_done_valid = 4'b1000;
      pipe_flush    = 1'b1;
      step();
      pipe_flush    = 1'b0;
      fu_done_valid = '0;
      chk("t5_valid_e1", 32'(cdb_valid), 32'h0);
      chk("t5_ready_e1", 32'(fu_done_ready), 32'hF);
      chk("t5_stall_e1", 32'(cdb_stall), 32'h0);
      step();
      chk("t5_valid_e2", 32'(cdb_valid), 32'h0);
      step();
      chk("t5_valid_e3", 32'(cdb_valid), 32'h0);

      // 6: reset and flush together mid-traffic
      do_reset();
      for (int i = 0; i < int'(FU_NUM); i++) set_pkt(i, 50 + i, 50 + i);
      fu_done_valid = 4'hF;
      step();
      fu_done_valid = '0;
      step();
      rst        = 1'b1;
      pipe_flush = 1'b1;
      step();
      rst        = 1'b0;
      pipe_flush = 1'b0;
      chk("t6_valid", 32'(cdb_valid), 32'h0);
      chk("t6_prn0", 32'(cdb_prn[0]), 32'h0);
      chk("t6_rob0", 32'(cdb_rob_entry[0]), 32'h0);
      chk("t6_prn1", 32'(cdb_prn[1]), 32'h0);
      chk("t6_ready", 32'(fu_done_ready), 32'hF);
      chk("t6_stall", 32'(cdb_stall), 32'h0);
      for (int i = 0; i < int'(FU_NUM); i++) set_pkt(i, 60 + i, 60 + i);
      fu_done_valid = 4'hF;
      step();
      fu_done_valid = '0;
      chk("t6_stall_ptr0", 32'(cdb_stall), 32'hC);
      step();
      chk("t6_prn0_post", 32'(cdb_prn[0]), 32'd60);
      chk("t6_prn1_post", 32'(cdb_prn[1]), 32'd61);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
